// File: rtl/bram_capture_pkg.sv
// bram_capture_pkg
//   Shared definitions for write_bram_capture: capture FSM state encoding,
//   AXI-lite response codes and the decimation reload helper.
package bram_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // A decimation rate of 0 behaves like 1, so both reload to 0.
  function automatic logic [31:0] dec_reload(input logic [31:0] rate);
    return (rate == 32'd0) ? 32'd0 : rate - 32'd1;
  endfunction

endpackage

// File: rtl/capture_bram.sv
// capture_bram
//   Simple dual-port RAM: one write port and one registered read port.
//   Read-first: a read of the address written in the same cycle returns the
//   old word. The read register only updates when i_re is high, so o_rdata
//   holds its value between reads. Contents are never cleared.
// Ports
//   clk      clock
//   i_we     write enable
//   i_waddr  write word address
//   i_wdata  write data
//   i_re     read enable (loads the output register)
//   i_raddr  read word address
//   o_rdata  registered read data
module capture_bram #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [0:(2**ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/write_bram_capture.sv
// write_bram_capture
//   Captures din at a decimated rate into an internal BRAM; the PS reads the
//   buffer over AXI-lite (writes are refused with SLVERR). Single-shot fills
//   the buffer once, continuous mode runs a wrap-around ring until
//   en_capture drops.
// Build option
//   CAPTURE_LEVEL_TRIG_EN : adds trig_level; ARMED waits for an upward signed
//                           crossing of din through trig_level.
// Ports
//   axi_clock, rst_n       clock, synchronous active-low reset
//   s_axil_aw*/w*/b*       AXI-lite write channels (always answered SLVERR)
//   s_axil_ar*/r*          AXI-lite read channels (BRAM readback)
//   rst_capture            synchronous capture restart to IDLE
//   en_capture             rising edge starts a capture
//   continous              1 = ring buffer, 0 = single shot
//   dec_rate               one sample written every dec_rate cycles
//   din                    sample stream
//   trig_level             signed trigger threshold (option only)
//   finish_capture         capture complete / stopped
//   capturing              high in ARMED or CAPTURE
//   wr_addr                next BRAM address to be written
//
// state   | meaning
// IDLE    | waiting for an en_capture rising edge
// ARMED   | waiting for the trigger condition
// CAPTURE | writing decimated samples
// DONE    | buffer complete or ring stopped, finish_capture high
module write_bram_capture
  import bram_capture_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      axi_clock,
  input  logic                      rst_n,
  input  logic [ADDR_WIDTH+1:0]     s_axil_awaddr,
  input  logic [2:0]                s_axil_awprot,
  input  logic                      s_axil_awvalid,
  output logic                      s_axil_awready,
  input  logic [DATA_WIDTH-1:0]     s_axil_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axil_wstrb,
  input  logic                      s_axil_wvalid,
  output logic                      s_axil_wready,
  output logic [1:0]                s_axil_bresp,
  output logic                      s_axil_bvalid,
  input  logic                      s_axil_bready,
  input  logic [ADDR_WIDTH+1:0]     s_axil_araddr,
  input  logic [2:0]                s_axil_arprot,
  input  logic                      s_axil_arvalid,
  output logic                      s_axil_arready,
  output logic [DATA_WIDTH-1:0]     s_axil_rdata,
  output logic [1:0]                s_axil_rresp,
  output logic                      s_axil_rvalid,
  input  logic                      s_axil_rready,
  input  logic                      rst_capture,
  input  logic                      en_capture,
  input  logic                      continous,
  input  logic [31:0]               dec_rate,
  input  logic [DATA_WIDTH-1:0]     din,
`ifdef CAPTURE_LEVEL_TRIG_EN
  input  logic [DATA_WIDTH-1:0]     trig_level,
`endif
  output logic                      finish_capture,
  output logic                      capturing,
  output logic [ADDR_WIDTH-1:0]     wr_addr
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  cap_state_t             r_state;
  logic                   r_en_d;
  logic [31:0]            r_dec_cnt;
  logic [ADDR_WIDTH-1:0]  r_wr_addr;
  logic                   r_finish;
  logic                   r_capturing;

  logic                   r_arready;
  logic                   r_rvalid;
  logic                   r_awready;
  logic                   r_bvalid;

  logic                   w_en_rise;
  logic                   w_trig_hit;
  logic                   w_wr_en;
  logic                   w_ar_hs;
  logic                   w_rvalid_nxt;
  logic                   w_aw_go;
  logic                   w_aw_hs;
  logic [DATA_WIDTH-1:0]  w_bram_q;
  logic                   w_unused_ok;

  assign w_en_rise = en_capture & ~r_en_d;

`ifdef CAPTURE_LEVEL_TRIG_EN
  logic [DATA_WIDTH-1:0] r_din_prev;

  always_ff @(posedge axi_clock) begin
    if (!rst_n) r_din_prev <= '0;
    else        r_din_prev <= din;
  end

  assign w_trig_hit = ($signed(din) >= $signed(trig_level)) &&
                      ($signed(r_din_prev) < $signed(trig_level));
`else
  assign w_trig_hit = 1'b1;
`endif

  // The write strobe is combinational so that the sample present in the
  // writing cycle is the one stored. With level trigger the crossing sample
  // itself is written on the ARMED->CAPTURE edge.
  always_comb begin
    w_wr_en = 1'b0;
    if (rst_n && !rst_capture) begin
      case (r_state)
`ifdef CAPTURE_LEVEL_TRIG_EN
        ST_ARMED:   w_wr_en = w_trig_hit;
`endif
        ST_CAPTURE: w_wr_en = (r_dec_cnt == 32'd0) && (!continous || en_capture);
        default:    w_wr_en = 1'b0;
      endcase
    end
  end

  always_ff @(posedge axi_clock) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_en_d      <= 1'b0;
      r_dec_cnt   <= 32'd0;
      r_wr_addr   <= '0;
      r_finish    <= 1'b0;
      r_capturing <= 1'b0;
    end else begin
      r_en_d <= en_capture;
      if (rst_capture) begin
        r_state     <= ST_IDLE;
        r_finish    <= 1'b0;
        r_capturing <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE, ST_DONE: begin
            if (w_en_rise) begin
              r_state     <= ST_ARMED;
              r_wr_addr   <= '0;
              r_dec_cnt   <= 32'd0;
              r_finish    <= 1'b0;
              r_capturing <= 1'b1;
            end
          end
          ST_ARMED: begin
            if (w_trig_hit) begin
              r_state <= ST_CAPTURE;
              if (w_wr_en) begin
                r_wr_addr <= r_wr_addr + 1'b1;
                r_dec_cnt <= dec_reload(dec_rate);
              end
            end
          end
          ST_CAPTURE: begin
            if (continous && !en_capture) begin
              r_state     <= ST_DONE;
              r_finish    <= 1'b1;
              r_capturing <= 1'b0;
            end else if (w_wr_en) begin
              r_wr_addr <= r_wr_addr + 1'b1;
              r_dec_cnt <= dec_reload(dec_rate);
              if (!continous && (r_wr_addr == LAST_ADDR)) begin
                r_state     <= ST_DONE;
                r_finish    <= 1'b1;
                r_capturing <= 1'b0;
              end
            end else begin
              r_dec_cnt <= r_dec_cnt - 32'd1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign finish_capture = r_finish;
  assign capturing      = r_capturing;
  assign wr_addr        = r_wr_addr;

  // Read channel: arready is the registered complement of the next rvalid,
  // which keeps it 0 during reset and equal to !rvalid afterwards.
  assign w_ar_hs      = s_axil_arvalid && r_arready;
  assign w_rvalid_nxt = w_ar_hs || (r_rvalid && !s_axil_rready);

  // Write channel: one-cycle ready pulse, response after the handshake.
  assign w_aw_go = s_axil_awvalid && s_axil_wvalid && !r_bvalid && !r_awready;
  assign w_aw_hs = r_awready && s_axil_awvalid && s_axil_wvalid;

  always_ff @(posedge axi_clock) begin
    if (!rst_n) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
    end else begin
      r_rvalid  <= w_rvalid_nxt;
      r_arready <= !w_rvalid_nxt;
      r_awready <= w_aw_go;
      if (w_aw_hs)                     r_bvalid <= 1'b1;
      else if (r_bvalid && s_axil_bready) r_bvalid <= 1'b0;
    end
  end

  capture_bram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_bram (
    .clk     (axi_clock),
    .i_we    (w_wr_en),
    .i_waddr (r_wr_addr),
    .i_wdata (din),
    .i_re    (w_ar_hs),
    .i_raddr (s_axil_araddr[ADDR_WIDTH+1:2]),
    .o_rdata (w_bram_q)
  );

  assign s_axil_arready = r_arready;
  assign s_axil_rvalid  = r_rvalid;
  assign s_axil_rdata   = r_rvalid ? w_bram_q : '0;
  assign s_axil_rresp   = RESP_OKAY;
  assign s_axil_awready = r_awready;
  assign s_axil_wready  = r_awready;
  assign s_axil_bvalid  = r_bvalid;
  assign s_axil_bresp   = RESP_SLVERR;

  // The buffer is read-only and byte lanes are irrelevant.
  assign w_unused_ok = ^{s_axil_awaddr, s_axil_awprot, s_axil_wdata,
                         s_axil_wstrb, s_axil_arprot, s_axil_araddr[1:0]};

endmodule

// File: tb/tb_write_bram_capture.sv
module tb_write_bram_capture;

  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [AW+1:0] awaddr;
  logic [2:0]    awprot;
  logic          awvalid, awready;
  logic [DW-1:0] wdata;
  logic [3:0]    wstrb;
  logic          wvalid, wready;
  logic [1:0]    bresp;
  logic          bvalid, bready;
  logic [AW+1:0] araddr;
  logic [2:0]    arprot;
  logic          arvalid, arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rvalid, rready;
  logic          rst_capture, en_capture, continous;
  logic [31:0]   dec_rate;
  logic [DW-1:0] din;
`ifdef CAPTURE_LEVEL_TRIG_EN
  logic [DW-1:0] trig_level;
`endif
  logic          finish_capture, capturing;
  logic [AW-1:0] wr_addr;

  write_bram_capture #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .axi_clock      (clk),
    .rst_n          (rst_n),
    .s_axil_awaddr  (awaddr),
    .s_axil_awprot  (awprot),
    .s_axil_awvalid (awvalid),
    .s_axil_awready (awready),
    .s_axil_wdata   (wdata),
    .s_axil_wstrb   (wstrb),
    .s_axil_wvalid  (wvalid),
    .s_axil_wready  (wready),
    .s_axil_bresp   (bresp),
    .s_axil_bvalid  (bvalid),
    .s_axil_bready  (bready),
    .s_axil_araddr  (araddr),
    .s_axil_arprot  (arprot),
    .s_axil_arvalid (arvalid),
    .s_axil_arready (arready),
    .s_axil_rdata   (rdata),
    .s_axil_rresp   (rresp),
    .s_axil_rvalid  (rvalid),
    .s_axil_rready  (rready),
    .rst_capture    (rst_capture),
    .en_capture     (en_capture),
    .continous      (continous),
    .dec_rate       (dec_rate),
    .din            (din),
`ifdef CAPTURE_LEVEL_TRIG_EN
    .trig_level     (trig_level),
`endif
    .finish_capture (finish_capture),
    .capturing      (capturing),
    .wr_addr        (wr_addr)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [31:0] din_off  = 32'd0;
  logic [DW-1:0] exp_mem [DEPTH];
  bit            known   [DEPTH];

  // din is a ramp: the sample seen at posedge number P equals P-1+din_off.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    din = 32'(cyc) + din_off;
  endtask

  task automatic axi_read(input int idx, output logic [DW-1:0] data, output bit ok);
    int w;
    ok = 1'b0;
    data = '0;
    araddr = 10'(idx * 4);
    arvalid = 1'b1;
    rready = 1'b0;
    w = 0;
    while (arready !== 1'b1 && w < 10) begin tick(); w++; end
    if (arready !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL arready_timeout: arready=%b after %0d cycles, expected 1", arready, w);
      arvalid = 1'b0;
      return;
    end
    tick();
    arvalid = 1'b0;
    n_checks++;
    if (rvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL rvalid_latency: rvalid=%b one cycle after handshake, expected 1", rvalid);
    end
    data = rdata;
    ok = 1'b1;
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  task automatic check_mem(input string tag, input int idx);
    logic [DW-1:0] got;
    bit ok;
    axi_read(idx, got, ok);
    if (ok) begin
      n_checks++;
      if (got !== exp_mem[idx]) begin
        n_fail++;
        $display("FAIL %s: BRAM[%0d] read %h, expected %h", tag, idx, got, exp_mem[idx]);
      end
    end
  endtask

  // Runs one capture from IDLE/DONE. Model: the en edge is seen at posedge
  // c0+1 (ARMED), CAPTURE from c0+2, and write n lands at posedge c0+3+n*d
  // carrying first_val + n*d.
  task automatic do_capture(input string tag, input int d_set, input bit cont,
                            input int n_cont, input logic [31:0] first_val);
    int d, total, c0, last_p, bad, p, wexp;
    logic [AW-1:0] wa;
    rst_capture = 1'b0;
    en_capture  = 1'b0;
    continous   = cont;
    dec_rate    = 32'(d_set);
    tick(); tick();
    d     = (d_set == 0) ? 1 : d_set;
    total = cont ? n_cont : DEPTH;
    en_capture = 1'b1;
    c0 = cyc;
    din_off = first_val - 32'(c0 + 2);
    last_p = c0 + 3 + (total - 1) * d;
    bad = 0;
    while (cyc < last_p) begin
      tick();
      p = cyc;
      wexp = (p >= c0 + 3) ? ((p - c0 - 3) / d + 1) : 0;
      wa = wexp[AW-1:0];
      if (p < last_p || cont) begin
        if (wr_addr !== wa) bad++;
        if (capturing !== 1'b1 || finish_capture !== 1'b0) bad++;
      end
      // single shot ignores en level and new rising edges once started
      if (!cont && p == c0 + 50) en_capture = 1'b0;
      if (!cont && p == c0 + 60) en_capture = 1'b1;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL %s_track: %0d cycle mismatches in wr_addr/capturing/finish, expected 0", tag, bad);
    end
    if (cont) begin
      en_capture = 1'b0;
      tick();
      n_checks++;
      if (wr_addr !== 8'(total)) begin
        n_fail++;
        $display("FAIL %s_wr_addr: wr_addr=%0d, expected %0d", tag, wr_addr, total % DEPTH);
      end
    end
    n_checks++;
    if (finish_capture !== 1'b1 || capturing !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done: finish=%b capturing=%b, expected 1 0", tag, finish_capture, capturing);
    end
    for (int n = 0; n < total; n++) begin
      exp_mem[n % DEPTH] = first_val + 32'(n * d);
      known[n % DEPTH] = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (finish_capture !== 1'b0 || capturing !== 1'b0 || wr_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_status: finish=%b capturing=%b wr_addr=%0d, expected 0 0 0",
               finish_capture, capturing, wr_addr);
    end
    n_checks++;
    if (awready !== 1'b0 || wready !== 1'b0 || bvalid !== 1'b0 || arready !== 1'b0 || rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_axi_hs: awready=%b wready=%b bvalid=%b arready=%b rvalid=%b, expected all 0",
               awready, wready, bvalid, arready, rvalid);
    end
    n_checks++;
    if (rdata !== '0 || bresp !== 2'b10 || rresp !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_axi_data: rdata=%h bresp=%b rresp=%b, expected 0 10 00", rdata, bresp, rresp);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (arready !== 1'b1) begin
      n_fail++;
      $display("FAIL arready_idle: arready=%b, expected 1", arready);
    end
  endtask

  task automatic test_single_shot();
    do_capture("single_d1", 1, 1'b0, 0, 32'd0);
    for (int i = 0; i < DEPTH; i++) check_mem("single_ramp", i);
    n_checks++;
    if (finish_capture !== 1'b1) begin
      n_fail++;
      $display("FAIL finish_hold: finish=%b long after completion, expected 1", finish_capture);
    end
  endtask

  task automatic test_decimation();
    int d;
    do_capture("dec4", 4, 1'b0, 0, $urandom);
    check_mem("dec4", 0);
    check_mem("dec4", 255);
    repeat (10) check_mem("dec4", $urandom_range(DEPTH - 1));
    d = $urandom_range(7, 2);
    do_capture("dec_rand", d, 1'b0, 0, $urandom);
    repeat (10) check_mem("dec_rand", $urandom_range(DEPTH - 1));
  endtask

  task automatic test_continuous();
    // dec_rate 0 behaves like 1
    do_capture("ring", 0, 1'b1, 300, $urandom);
    check_mem("ring", 0);
    check_mem("ring", 43);
    check_mem("ring", 44);
    check_mem("ring", 255);
    repeat (6) check_mem("ring", $urandom_range(DEPTH - 1));
  endtask

`ifdef CAPTURE_LEVEL_TRIG_EN
  task automatic test_level_trig();
    int c0, px, bad, w;
    trig_level  = 32'd100;
    continous   = 1'b0;
    dec_rate    = 32'd1;
    en_capture  = 1'b0;
    rst_capture = 1'b0;
    tick(); tick();
    din_off = 32'd150 - 32'(cyc);
    din = 32'(cyc) + din_off;
    en_capture = 1'b1;
    bad = 0;
    repeat (10) begin
      tick();
      if (capturing !== 1'b1 || wr_addr !== '0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL trig_above_level: %0d cycles left ARMED without a crossing, expected 0", bad);
    end
    rst_capture = 1'b1; en_capture = 1'b0;
    tick();
    rst_capture = 1'b0;
    tick();
    din_off = 32'hFFFF_FFFB - 32'(cyc);
    din = 32'(cyc) + din_off;
    en_capture = 1'b1;
    c0 = cyc;
    px = c0 + 106;
    bad = 0;
    while (cyc < px) begin
      tick();
      if (capturing !== 1'b1 || wr_addr !== ((cyc >= px) ? 8'd1 : 8'd0)) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL trig_crossing: %0d cycle mismatches around din=100, expected 0", bad);
    end
    w = 0;
    while (cyc < px + 255 && w < 400) begin tick(); w++; end
    n_checks++;
    if (finish_capture !== 1'b1) begin
      n_fail++;
      $display("FAIL trig_done: finish=%b, expected 1", finish_capture);
    end
    for (int n = 0; n < DEPTH; n++) begin
      exp_mem[n] = 32'(100 + n);
      known[n] = 1'b1;
    end
    check_mem("trig_first", 0);
    check_mem("trig_second", 1);
    check_mem("trig_last", 255);
  endtask
`endif

  task automatic test_axi_read_hold();
    int w, bad;
    araddr = 10'h10;
    arvalid = 1'b1;
    rready = 1'b0;
    w = 0;
    while (arready !== 1'b1 && w < 10) begin tick(); w++; end
    tick();
    arvalid = 1'b0;
    n_checks++;
    if (rvalid !== 1'b1 || rdata !== exp_mem[4]) begin
      n_fail++;
      $display("FAIL read_0x10: rvalid=%b rdata=%h, expected 1 %h", rvalid, rdata, exp_mem[4]);
    end
    bad = 0;
    repeat (5) begin
      tick();
      if (rvalid !== 1'b1 || rdata !== exp_mem[4] || arready !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL read_hold: %0d stalled cycles changed rvalid/rdata/arready, expected 0", bad);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    n_checks++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      n_fail++;
      $display("FAIL read_release: rvalid=%b arready=%b, expected 0 1", rvalid, arready);
    end
  endtask

  task automatic test_axi_write_and_restart();
    int w;
    awaddr = '0; wdata = 32'h0000_DEAD; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    w = 0;
    while (awready !== 1'b1 && w < 10) begin tick(); w++; end
    n_checks++;
    if (awready !== 1'b1 || wready !== 1'b1) begin
      n_fail++;
      $display("FAIL write_ready: awready=%b wready=%b, expected 1 1", awready, wready);
    end
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    n_checks++;
    if (bvalid !== 1'b1 || bresp !== 2'b10 || awready !== 1'b0) begin
      n_fail++;
      $display("FAIL write_resp: bvalid=%b bresp=%b awready=%b, expected 1 10 0", bvalid, bresp, awready);
    end
    tick(); tick();
    n_checks++;
    if (bvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL bvalid_hold: bvalid=%b while bready low, expected 1", bvalid);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    n_checks++;
    if (bvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL bvalid_clear: bvalid=%b after bready, expected 0", bvalid);
    end
    check_mem("write_ignored", 0);

    continous = 1'b0; dec_rate = 32'd1; en_capture = 1'b0; rst_capture = 1'b0;
    tick(); tick();
    en_capture = 1'b1;
    repeat (20) tick();
    n_checks++;
    if (capturing !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_running: capturing=%b, expected 1", capturing);
    end
    rst_capture = 1'b1;
    tick();
    rst_capture = 1'b0;
    n_checks++;
    if (capturing !== 1'b0 || finish_capture !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_capture: capturing=%b finish=%b, expected 0 0", capturing, finish_capture);
    end
    en_capture = 1'b0;
    tick(); tick();
    en_capture = 1'b1; rst_capture = 1'b1;
    tick();
    rst_capture = 1'b0;
    tick();
    n_checks++;
    if (capturing !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_wins_over_edge: capturing=%b, expected 0", capturing);
    end
    en_capture = 1'b0;
    tick();
    en_capture = 1'b1;
    tick();
    n_checks++;
    if (capturing !== 1'b1 || wr_addr !== '0) begin
      n_fail++;
      $display("FAIL restart_addr: capturing=%b wr_addr=%0d, expected 1 0", capturing, wr_addr);
    end
    repeat (4) tick();
    rst_capture = 1'b1;
    tick();
    rst_capture = 1'b0;
    en_capture = 1'b0;
    for (int i = 0; i < 64; i++) known[i] = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    rst_capture = 1'b0; en_capture = 1'b0; continous = 1'b0; dec_rate = 32'd1;
    din = '0;
`ifdef CAPTURE_LEVEL_TRIG_EN
    trig_level = 32'd100;
`endif
    for (int i = 0; i < DEPTH; i++) begin exp_mem[i] = '0; known[i] = 1'b0; end

    test_reset();
`ifdef CAPTURE_LEVEL_TRIG_EN
    test_level_trig();
`else
    test_single_shot();
    test_decimation();
    test_continuous();
`endif
    test_axi_read_hold();
    test_axi_write_and_restart();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
